// File: rtl/fifo_stream_reader_if.sv
// Output stream bundle of the FIFO read-side drain engine.
// A beat transfers on a clk_rd posedge where m_valid && m_ready; once m_valid is
// raised, m_data and m_last hold steady until that transfer, and m_ready may be
// driven freely (it never has to wait for m_valid).
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a FIFO with one-cycle registered read latency into a 2-entry skid buffer
// and presents it as a burst-framed valid/ready stream with a sticky read-error bit.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                   clk_rd,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   fifo_empty,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                   fifo_read_error,
    output logic                   fifo_rd_en,
    fifo_stream_reader_if.master   m_if,
    output logic [15:0]            burst_count,
    output logic                   read_err,
    output logic [1:0]             level,
    output logic                   busy
);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(BURST_LEN - 1);

    logic                  v1_q, v1_d;
    logic [1:0]            occ_q, occ_d;
    logic                  head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q [2];
    logic [DATA_WIDTH-1:0] skid_d [2];
    logic [BW-1:0]         beat_idx_q, beat_idx_d;
    logic [15:0]           burst_count_q, burst_count_d;
    logic                  read_err_q, read_err_d;

    logic       m_valid;
    logic       m_last;
    logic       pop;
    logic       tail;
    logic       underrun;
    logic [2:0] committed;
    logic [2:0] allowance;

    assign m_valid = (occ_q != 2'd0);
    assign m_last  = m_valid && (beat_idx_q == LAST_IDX);
    assign pop     = m_valid && m_if.m_ready;

    // Words held plus the one in flight may exceed 1 only by what leaves this cycle,
    // so a newly issued read always finds a free skid slot when it lands.
    assign committed  = {1'b0, occ_q} + {2'b00, v1_q};
    assign allowance  = 3'd1 + {2'b00, pop};
    assign fifo_rd_en = rst_n && !clear && !fifo_empty && (committed <= allowance);

    assign tail     = head_q ^ occ_q[0];
    assign underrun = v1_q && (occ_q == 2'd2) && !pop;

    assign m_if.m_valid = m_valid;
    assign m_if.m_data  = skid_q[head_q];
    assign m_if.m_last  = m_last;
    assign burst_count  = burst_count_q;
    assign read_err     = read_err_q;
    assign level        = occ_q;
    assign busy         = m_valid || v1_q;

    always_comb begin
        v1_d          = v1_q;
        occ_d         = occ_q;
        head_d        = head_q;
        skid_d        = skid_q;
        beat_idx_d    = beat_idx_q;
        burst_count_d = burst_count_q;
        read_err_d    = read_err_q;

        if (clear) begin
            // Dropping v1 here discards the word the FIFO returns for the last read.
            v1_d          = 1'b0;
            occ_d         = 2'd0;
            head_d        = 1'b0;
            skid_d        = '{default: '0};
            beat_idx_d    = '0;
            burst_count_d = 16'd0;
            read_err_d    = 1'b0;
        end else begin
            v1_d   = fifo_rd_en;
            head_d = head_q ^ pop;

            if (v1_q && !underrun) begin
                skid_d[tail] = fifo_rd_data;
            end

            case ({v1_q && !underrun, pop})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase

            if (pop) begin
                beat_idx_d = (beat_idx_q == LAST_IDX) ? '0 : beat_idx_q + 1'b1;
                if (m_last) begin
                    burst_count_d = burst_count_q + 16'd1;
                end
            end

            read_err_d = read_err_q || fifo_read_error || underrun;
        end
    end

    always_ff @(posedge clk_rd) begin
        if (!rst_n) begin
            v1_q          <= 1'b0;
            occ_q         <= 2'd0;
            head_q        <= 1'b0;
            skid_q        <= '{default: '0};
            beat_idx_q    <= '0;
            burst_count_q <= 16'd0;
            read_err_q    <= 1'b0;
        end else begin
            v1_q          <= v1_d;
            occ_q         <= occ_d;
            head_q        <= head_d;
            skid_q        <= skid_d;
            beat_idx_q    <= beat_idx_d;
            burst_count_q <= burst_count_d;
            read_err_q    <= read_err_d;
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a BURST_LEN=4 instance driven against a
// small FIFO model, plus a BURST_LEN=1 instance run long enough to wrap burst_count.
module tb_fifo_stream_reader;
    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clk_rd = 1'b0;
    always #5 clk_rd = ~clk_rd;

    logic          rst_n           = 1'b0;
    logic          clear           = 1'b0;
    logic          fifo_read_error = 1'b0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data    = '0;
    logic          fifo_rd_en;
    logic [15:0]   burst_count;
    logic          read_err;
    logic [1:0]    level;
    logic          busy;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) s_if ();
    initial s_if.m_ready = 1'b0;

    fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(4)) u_dut (
        .clk_rd          (clk_rd),
        .rst_n           (rst_n),
        .clear           (clear),
        .fifo_empty      (fifo_empty),
        .fifo_rd_data    (fifo_rd_data),
        .fifo_read_error (fifo_read_error),
        .fifo_rd_en      (fifo_rd_en),
        .m_if            (s_if),
        .burst_count     (burst_count),
        .read_err        (read_err),
        .level           (level),
        .busy            (busy)
    );

    // FIFO model: registered read data, flushed by clear like the real FIFO.
    logic [DW-1:0] mem [64];
    int            wr_ptr     = 0;
    int            rd_ptr     = 0;
    logic          fifo_flush = 1'b0;
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk_rd) begin
        if (fifo_flush || clear) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en) begin
            fifo_rd_data <= mem[rd_ptr % 64];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    // Credit-rule breach watcher: a word landing on a full skid with nothing leaving.
    int underrun_cnt = 0;
    always @(posedge clk_rd) begin
        if (rst_n && !clear && u_dut.v1_q && (u_dut.occ_q == 2'd2) &&
            !(s_if.m_valid && s_if.m_ready)) begin
            underrun_cnt <= underrun_cnt + 1;
        end
    end

    // ---------------- long-run instance (BURST_LEN = 1) ----------------
    logic          rst2_n = 1'b0;
    logic          rd_en2;
    logic [DW-1:0] rd_data2 = '0;
    logic [DW-1:0] src_cnt2 = '0;
    logic [15:0]   burst2;
    logic          read_err2;
    logic [1:0]    level2;
    logic          busy2;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) s2_if ();
    assign s2_if.m_ready = 1'b1;

    fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(1)) u_dut2 (
        .clk_rd          (clk_rd),
        .rst_n           (rst2_n),
        .clear           (1'b0),
        .fifo_empty      (1'b0),
        .fifo_rd_data    (rd_data2),
        .fifo_read_error (1'b0),
        .fifo_rd_en      (rd_en2),
        .m_if            (s2_if),
        .burst_count     (burst2),
        .read_err        (read_err2),
        .level           (level2),
        .busy            (busy2)
    );

    always @(posedge clk_rd) begin
        if (rd_en2) begin
            rd_data2 <= src_cnt2;
            src_cnt2 <= src_cnt2 + 1'b1;
        end
    end

    int          long_pops     = 0;
    int          long_bad_last = 0;
    int          long_bad_data = 0;
    logic [15:0] bc_pre_wrap   = 16'h1234;
    logic [15:0] bc_post_wrap  = 16'h1234;
    logic        long_done     = 1'b0;

    initial begin
        logic [DW-1:0] exp_d;
        exp_d = '0;
        repeat (2) @(negedge clk_rd);
        rst2_n = 1'b1;
        for (int c = 0; c < 70000 && long_pops < 65536; c++) begin
            @(negedge clk_rd);
            #1;
            if (s2_if.m_valid && s2_if.m_ready) begin
                if (!s2_if.m_last) long_bad_last++;
                if (s2_if.m_data !== exp_d) long_bad_data++;
                exp_d = exp_d + 1'b1;
                if (long_pops == 65535) bc_pre_wrap = burst2;
                long_pops++;
            end
        end
        @(negedge clk_rd);
        #1;
        bc_post_wrap = burst2;
        long_done    = 1'b1;
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q [$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk_rd);
        rst_n           = 1'b0;
        clear           = 1'b0;
        s_if.m_ready    = 1'b0;
        fifo_read_error = 1'b0;
        fifo_flush      = 1'b1;
        exp_q.delete();
        @(negedge clk_rd);
        fifo_flush = 1'b0;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        mem[wr_ptr % 64] = w;
        wr_ptr           = wr_ptr + 1;
        exp_q.push_back(w);
    endtask

    // Accept n beats with m_ready following pat[0..3] cyclically; checks order,
    // framing, stall stability, occupancy and reads issued while stalled.
    task automatic drain(input string tag, input int n, input logic [3:0] pat, input bit gap_check);
        int            beats       = 0;
        int            idx         = 0;
        int            stall_reads = 0;
        int            max_stall   = 0;
        int            gaps        = 0;
        int            lvl_bad     = 0;
        int            stab_bad    = 0;
        bit            started     = 0;
        logic          prev_stall  = 1'b0;
        logic [DW-1:0] prev_data   = '0;
        logic          prev_last   = 1'b0;
        logic          pop;
        logic [DW-1:0] exp_w;
        for (int cyc = 0; cyc < 200 && beats < n; cyc++) begin
            @(negedge clk_rd);
            s_if.m_ready = pat[idx % 4];
            idx++;
            #1;
            pop = s_if.m_valid && s_if.m_ready;
            if (level > 2'd2) lvl_bad++;
            if (prev_stall && (s_if.m_data !== prev_data || s_if.m_last !== prev_last)) stab_bad++;
            if (pop) stall_reads = 0;
            else if (fifo_rd_en) stall_reads++;
            if (stall_reads > max_stall) max_stall = stall_reads;
            if (gap_check && started && !s_if.m_valid) gaps++;
            if (pop) begin
                exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                check({tag, "_data"}, 32'(s_if.m_data), 32'(exp_w));
                check({tag, "_last"}, 32'(s_if.m_last), 32'((beats % 4) == 3));
                beats++;
                started = 1;
            end
            prev_stall = s_if.m_valid && !s_if.m_ready;
            prev_data  = s_if.m_data;
            prev_last  = s_if.m_last;
        end
        check({tag, "_beats"}, 32'(beats), 32'(n));
        check({tag, "_level_max"}, 32'(lvl_bad), 32'd0);
        check({tag, "_stall_stable"}, 32'(stab_bad), 32'd0);
        check({tag, "_reads_in_stall_le2"}, 32'(max_stall <= 2), 32'd1);
        if (gap_check) check({tag, "_gaps"}, 32'(gaps), 32'd0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        // Reset with three words waiting, then first-word latency and stall cap.
        do_reset();
        push_word(8'hA0);
        push_word(8'hA1);
        push_word(8'hA2);
        @(negedge clk_rd);
        #1;
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_m_valid", 32'(s_if.m_valid), 32'd0);
        check("rst_m_data", 32'(s_if.m_data), 32'd0);
        check("rst_m_last", 32'(s_if.m_last), 32'd0);
        check("rst_burst_count", 32'(burst_count), 32'd0);
        check("rst_read_err", 32'(read_err), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        #1;
        check("c0_rd_en", 32'(fifo_rd_en), 32'd1);
        check("c0_m_valid", 32'(s_if.m_valid), 32'd0);
        @(negedge clk_rd);
        #1;
        check("c1_m_valid", 32'(s_if.m_valid), 32'd0);
        check("c1_busy", 32'(busy), 32'd1);
        @(negedge clk_rd);
        #1;
        check("c2_m_valid", 32'(s_if.m_valid), 32'd1);
        check("c2_m_data", 32'(s_if.m_data), 32'hA0);
        check("c2_level", 32'(level), 32'd1);
        check("c2_rd_en_blocked", 32'(fifo_rd_en), 32'd0);
        @(negedge clk_rd);
        #1;
        check("c3_level", 32'(level), 32'd2);
        check("c3_m_data_held", 32'(s_if.m_data), 32'hA0);
        check("c3_rd_en_blocked", 32'(fifo_rd_en), 32'd0);
        exp_q.pop_front();
        exp_q.push_front(8'hA0);
        drain("rst3", 3, 4'b1111, 1'b0);

        // 16 words, m_ready held high: back-to-back beats, four bursts.
        do_reset();
        for (int i = 0; i < 16; i++) push_word(DW'(i));
        rst_n = 1'b1;
        drain("stream", 16, 4'b1111, 1'b1);
        @(negedge clk_rd);
        #1;
        check("stream_burst_count", 32'(burst_count), 32'd4);
        check("stream_idle_level", 32'(level), 32'd0);
        check("stream_idle_busy", 32'(busy), 32'd0);

        // Same words with m_ready cycling 1,0,0,1.
        do_reset();
        for (int i = 0; i < 16; i++) push_word(DW'(i));
        rst_n = 1'b1;
        drain("stall", 16, 4'b1001, 1'b0);
        @(negedge clk_rd);
        #1;
        check("stall_burst_count", 32'(burst_count), 32'd4);

        // Clear mid-burst with a read in flight.
        do_reset();
        for (int i = 0; i < 8; i++) push_word(DW'(8'h20 + i));
        rst_n = 1'b1;
        drain("pre_clr", 2, 4'b1111, 1'b0);
        @(negedge clk_rd);
        s_if.m_ready = 1'b0;
        clear        = 1'b1;
        #1;
        check("clr_rd_en", 32'(fifo_rd_en), 32'd0);
        check("clr_in_flight_busy", 32'(busy), 32'd1);
        exp_q.delete();
        @(negedge clk_rd);
        clear = 1'b0;
        #1;
        check("post_clr_m_valid", 32'(s_if.m_valid), 32'd0);
        check("post_clr_level", 32'(level), 32'd0);
        check("post_clr_burst_count", 32'(burst_count), 32'd0);
        check("post_clr_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 8; i++) push_word(DW'(8'h30 + i));
        drain("post_clr", 8, 4'b1111, 1'b1);
        @(negedge clk_rd);
        #1;
        check("post_clr_bursts", 32'(burst_count), 32'd2);

        // Sticky read error, cleared by clear and by reset.
        do_reset();
        rst_n = 1'b1;
        @(negedge clk_rd);
        #1;
        check("err_idle", 32'(read_err), 32'd0);
        fifo_read_error = 1'b1;
        @(negedge clk_rd);
        fifo_read_error = 1'b0;
        #1;
        check("err_set", 32'(read_err), 32'd1);
        repeat (3) @(negedge clk_rd);
        #1;
        check("err_sticky", 32'(read_err), 32'd1);
        clear = 1'b1;
        @(negedge clk_rd);
        clear = 1'b0;
        #1;
        check("err_cleared_by_clear", 32'(read_err), 32'd0);
        fifo_read_error = 1'b1;
        @(negedge clk_rd);
        fifo_read_error = 1'b0;
        #1;
        check("err_set_again", 32'(read_err), 32'd1);
        rst_n = 1'b0;
        @(negedge clk_rd);
        #1;
        check("err_cleared_by_reset", 32'(read_err), 32'd0);
        rst_n = 1'b1;

        // Wait for the long BURST_LEN=1 run and collect its results.
        for (int i = 0; i < 80000 && !long_done; i++) @(negedge clk_rd);
        check("long_run_done", 32'(long_done), 32'd1);
        check("long_pops", 32'(long_pops), 32'd65536);
        check("long_every_beat_last", 32'(long_bad_last), 32'd0);
        check("long_data_order", 32'(long_bad_data), 32'd0);
        check("long_bc_ffff", 32'(bc_pre_wrap), 32'h0000FFFF);
        check("long_bc_wrap", 32'(bc_post_wrap), 32'd0);
        check("no_underrun", 32'(underrun_cnt), 32'd0);

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side drain engine for the FIFO, living in the `clk_rd` domain. It issues `rd_en` pulses against the FIFO's `empty` flag and absorbs the FIFO's one-cycle registered read latency in a 2-entry skid buffer. It presents the data as a valid/ready stream, framed into fixed-length bursts with a `m_last` marker. It also turns FIFO read errors into a sticky status bit.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of FIFO words and stream data.
- `BURST_LEN`, 4, beats per burst (≥1); `m_last` marks beat `BURST_LEN`.

Ports:
- `clk_rd`  in  1  read-domain clock; all logic rises on its posedge.
- `rst_n`  in  1  synchronous, active-low reset.
- `clear`  in  1  synchronous flush, same cycle the FIFO sees its `clear`.
- `fifo_empty`  in  1  FIFO EMPTY flag.
- `fifo_rd_data`  in  DATA_WIDTH  FIFO read data, valid the cycle after an accepted `rd_en`.
- `fifo_read_error`  in  1  FIFO read-error flag.
- `fifo_rd_en`  out  1  read strobe to the FIFO (combinational).
- `m_valid`  out  1  stream data valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  DATA_WIDTH  stream data (skid head).
- `m_last`  out  1  last beat of the current burst.
- `burst_count`  out  16  completed bursts, wraps 0xFFFF→0.
- `read_err`  out  1  sticky: set on `fifo_read_error` or `underrun`.
- `level`  out  2  skid occupancy, 0..2.
- `busy`  out  1  `level != 0` or a read is in flight.

## Operation
- State:
  - `v1`: read-in-flight flag, registered `fifo_rd_en`.
  - `occ` (0..2): skid occupancy, 2 data registers, head/tail index.
  - `beat_idx` (0..BURST_LEN-1).
  - `burst_count`.
  - `read_err`.
- `pop = m_valid & m_ready`.
- Issue rule: `fifo_rd_en = rst_n & !clear & !fifo_empty & (occ + v1 - pop <= 1)`.
  - This guarantees the skid never overflows.
  - It gives 1 beat/cycle sustained when `m_ready` is held high.
- Capture: when `v1`=1, `fifo_rd_data` is written to the skid tail at the end of that cycle.
  - Simultaneous capture and pop: `occ` is unchanged, head advances.
  - Capture with no pop: `occ`+1. Pop with no capture: `occ`-1.
- Stream rules:
  - `m_valid = (occ != 0)`; `m_data` is the head entry.
  - While `m_valid & !m_ready`, `m_data` and `m_last` stay stable.
- Framing:
  - `m_last = m_valid & (beat_idx == BURST_LEN-1)`.
  - On pop, `beat_idx` increments, and wraps to 0 after the last beat.
  - A pop with `m_last` increments `burst_count`, modulo 2^16.
  - With `BURST_LEN`=1, every beat is last.
- Errors:
  - `read_err` is set on any cycle with `fifo_read_error`=1.
  - `read_err` is set if `v1`=1 when `occ`=2 with no pop (`underrun` of the credit rule). This is unreachable by design and is a bench assertion.
  - `read_err` is cleared only by reset or `clear`.
- `clear`:
  - Next cycle: `occ`=0, `v1`=0, `beat_idx`=0, `burst_count`=0, `read_err`=0.
  - `fifo_rd_en` is 0 in the `clear` cycle.
  - In-flight data arriving the cycle after `clear` is discarded.
- Reset (`rst_n`=0 at posedge), same as `clear`. Output values:
  - `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `m_last`=0.
  - `burst_count`=0, `read_err`=0, `level`=0, `busy`=0.
  - Skid data registers are cleared to 0.
  - A mid-burst reset drops the partial burst; the next beat starts a new burst at `beat_idx` 0.

## Timing
- Cycle t: `fifo_empty`=0 and credit available → `fifo_rd_en`=1.
- Cycle t+1: `v1`=1 and `fifo_rd_data` is valid; it is captured at the end of t+1.
- Cycle t+2: `m_valid`=1 with that word.
- Latency from `rd_en` to `m_valid` is 2 cycles.
- Latency from FIFO non-empty to `m_valid` is 2 cycles.
- Back-to-back: with `m_ready`=1, `fifo_rd_en` stays high every cycle the FIFO is non-empty.
- Stall: after `m_ready` drops, at most 2 more words are read (the word in flight plus one issued the same cycle). Then `fifo_rd_en` holds 0 until a pop.
- Resume: the first pop re-enables `fifo_rd_en` in the same cycle (the `- pop` term).
- `burst_count` updates the cycle after the last-beat pop.

## Test plan
- Reset with FIFO holding 3 words → all outputs 0; after release `fifo_rd_en`=1 at cycle 0 and `m_valid`=1 at cycle 2.
- FIFO preloaded with 16 words 0x00..0x0F, `m_ready`=1:
  - 16 consecutive beats in order.
  - `m_last` on beats 3, 7, 11, 15.
  - `burst_count`=4.
  - No gaps after the first beat.
- Same 16 words with `m_ready` toggled 1,0,0,1 repeating:
  - Data is in order, with no drop or duplicate.
  - `level` never exceeds 2.
  - `m_data` is stable during stalls.
  - At most 2 reads occur after a stall starts.
- `clear` asserted mid-burst (after beat 1 accepted, one read in flight):
  - Next cycle `m_valid`=0, `level`=0, `burst_count`=0.
  - The in-flight word is discarded.
  - The following data starts with `m_last` on its 4th beat.
- Force `fifo_read_error`=1 for one cycle → `read_err`=1 and held; cleared only by `clear` or `rst_n`=0.
- `BURST_LEN`=1, 0xFFFF bursts preloaded in `burst_count` via a long run → `m_last` on every beat; `burst_count` wraps 0xFFFF→0x0000.
